// File: rtl/ext_int_ctrl.sv
// ext_int_ctrl: external interrupt controller (sync, glitch filter, edge/level detect, pending, priority ID)
// Ports: clk, reset (async active-low), ext_int_i raw pins (bit 0 = int_ext1),
//        bus_addr/bus_wdata/bus_we/bus_re/bus_rdata word-addressed register port,
//        irq_o masked request level, irq_id_o lowest active channel + 1 (0 = none).
module ext_int_ctrl #(
  parameter int N_INPUTS      = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_INPUTS-1:0] ext_int_i,
  input  logic [3:0]          bus_addr,
  input  logic [31:0]         bus_wdata,
  input  logic                bus_we,
  input  logic                bus_re,
  output logic [31:0]         bus_rdata,
  output logic                irq_o,
  output logic [3:0]          irq_id_o
);
  logic [N_INPUTS-1:0]   s1, s2, filt, prev, enable, pending, evt, active;
  logic [2*N_INPUTS-1:0] mode;
  logic [1:0]            sel;
  logic [31:0]           rd_val;
  logic                  unused_ok;
  assign sel       = bus_addr[3:2];
  assign unused_ok = &{1'b0, bus_addr[1:0], bus_wdata[31:2*N_INPUTS]};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= ext_int_i;
      s2   <= s1;
      prev <= filt;
    end
  if (FILTER_CYCLES == 0) begin : g_nofilt
    assign filt = s2;
  end else begin : g_filt
    for (genvar i = 0; i < N_INPUTS; i++) begin : g_ch
      logic             f;
      logic [CNT_W-1:0] cnt;
      // the level flips only after s2 has disagreed for FILTER_CYCLES consecutive samples
      always_ff @(posedge clk or negedge reset)
        if (!reset) begin
          f   <= 1'b0;
          cnt <= '0;
        end else if (s2[i] == f) begin
          cnt <= '0;
        end else if (cnt == CNT_W'(FILTER_CYCLES - 1)) begin
          f   <= s2[i];
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      assign filt[i] = f;
    end
  end
  always_comb begin
    evt = '0;
    for (int i = 0; i < N_INPUTS; i++)
      evt[i] = mode[2*i+:2] == 2'b00 ? filt[i] & ~prev[i] :
               mode[2*i+:2] == 2'b01 ? ~filt[i] & prev[i] :
               mode[2*i+:2] == 2'b10 ? filt[i] ^ prev[i] : filt[i];
  end
  assign active = pending & enable;
  assign irq_o  = |active;
  always_comb begin
    irq_id_o = '0;
    for (int i = N_INPUTS - 1; i >= 0; i--)
      if (active[i]) irq_id_o = 4'(i + 1);
  end
  assign rd_val = sel == 2'd0 ? 32'(enable) :
                  sel == 2'd1 ? 32'(mode) :
                  sel == 2'd2 ? 32'(pending) : 32'(irq_id_o);
  // a new event outranks a same-cycle write-1-to-clear
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      enable    <= '0;
      mode      <= '0;
      pending   <= '0;
      bus_rdata <= '0;
    end else begin
      if (bus_we && sel == 2'd0) enable <= bus_wdata[N_INPUTS-1:0];
      if (bus_we && sel == 2'd1) mode <= bus_wdata[2*N_INPUTS-1:0];
      pending <= (pending & ~((bus_we && sel == 2'd2) ? bus_wdata[N_INPUTS-1:0] : '0)) | (evt & enable);
      if (bus_re) bus_rdata <= rd_val;
    end
endmodule

// File: tb/tb_ext_int_ctrl.sv
// tb_ext_int_ctrl: directed self-checking bench for ext_int_ctrl (unfiltered and 4-cycle filter instances)
module tb_ext_int_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  p0 = '0, p4 = '0;
  logic [3:0]  bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic        bus_we = 1'b0, bus_re = 1'b0;
  logic [31:0] rdata0, rdata4;
  logic        irq0, irq4;
  logic [3:0]  id0, id4;
  int          vecs = 0, miscompares = 0;

  always #5 clk = ~clk;

  ext_int_ctrl #(.N_INPUTS(2), .FILTER_CYCLES(0), .CNT_W(4)) d0 (
    .clk(clk), .reset(reset), .ext_int_i(p0), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(rdata0), .irq_o(irq0), .irq_id_o(id0));

  ext_int_ctrl #(.N_INPUTS(2), .FILTER_CYCLES(4), .CNT_W(4)) d4 (
    .clk(clk), .reset(reset), .ext_int_i(p4), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(rdata4), .irq_o(irq4), .irq_id_o(id4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus_addr = a; bus_wdata = d; bus_we = 1'b1;
    tick();
    bus_we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    bus_addr = a; bus_re = 1'b1;
    tick();
    bus_re = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    #1;
    chk("reset_irq0", 32'(irq0), 0);
    chk("reset_id0", 32'(id0), 0);
    chk("reset_irq4", 32'(irq4), 0);
    chk("reset_rdata4", rdata4, 0);
    tick(); tick();
    reset = 1'b1;
    tick();
    // unfiltered rising-edge latency
    wr(4'h0, 1); wr(4'h4, 0);
    p0[0] = 1'b1;
    tick(); chk("lat_e1", 32'(irq0), 0);
    tick(); chk("lat_e2", 32'(irq0), 0);
    tick(); chk("lat_e3_irq", 32'(irq0), 1); chk("lat_e3_id", 32'(id0), 1);
    rd(4'hC); chk("id_reg", rdata0, 1);
    wr(4'h8, 1); chk("w1c_irq", 32'(irq0), 0);
    rd(4'h8); chk("w1c_pend", rdata0, 0);
    rd(4'h0); chk("enable_rd", rdata0, 1);
    bus_addr = 4'h0; bus_wdata = 3; bus_we = 1'b1; bus_re = 1'b1;
    tick();
    bus_we = 1'b0; bus_re = 1'b0;
    chk("rw_same_pre", rdata0, 1);
    rd(4'h0); chk("rw_same_post", rdata0, 3);
    wr(4'hC, 32'hF); rd(4'hC); chk("id_ro", rdata0, 0);
    p0 = '0;
    // filtered channel 1: glitch rejection then accepted pulse
    do_reset();
    wr(4'h0, 2);
    p4[1] = 1'b1;
    repeat (3) tick();
    p4[1] = 1'b0;
    repeat (10) tick();
    chk("glitch_irq", 32'(irq4), 0);
    rd(4'h8); chk("glitch_pend", rdata4, 0);
    p4[1] = 1'b1;
    repeat (4) tick();
    p4[1] = 1'b0;
    tick(); tick(); chk("pulse_e6", 32'(irq4), 0);
    tick(); chk("pulse_e7_irq", 32'(irq4), 1); chk("pulse_e7_id", 32'(id4), 2);
    // both channels, same-cycle rise, priority
    do_reset();
    wr(4'h0, 3);
    p4 = 2'b11;
    repeat (7) tick();
    chk("both_id", 32'(id4), 1);
    rd(4'h8); chk("both_pend", rdata4, 3);
    wr(4'h8, 1); chk("both_id_after1", 32'(id4), 2);
    wr(4'h8, 2); chk("both_id_after2", 32'(id4), 0); chk("both_irq_after2", 32'(irq4), 0);
    // level mode on ch0 with the pin held high
    wr(4'h4, 3);
    tick();
    wr(4'h8, 1);
    rd(4'h8); chk("level_held", rdata4, 1);
    p4[0] = 1'b0;
    repeat (8) tick();
    wr(4'h8, 1);
    rd(4'h8); chk("level_cleared", rdata4, 0);
    // both-edge mode: new event coincides with W1C
    wr(4'h4, 2);
    wr(4'h8, 1);
    p4[0] = 1'b1;
    repeat (6) tick();
    wr(4'h8, 1);
    rd(4'h8); chk("set_beats_clr", rdata4, 1);
    wr(4'h8, 1);
    rd(4'h8); chk("clr_no_event", rdata4, 0);
    // async reset mid-pulse with both pending
    wr(4'h4, 32'hA);
    p4 = 2'b00;
    repeat (8) tick();
    rd(4'h8); chk("pre_rst_pend", rdata4, 3);
    chk("pre_rst_irq", 32'(irq4), 1);
    rd(4'h0); chk("pre_rst_en", rdata4, 3);
    p4 = 2'b11;
    tick(); tick();
    #2 reset = 1'b0;
    #1;
    chk("arst_irq", 32'(irq4), 0);
    chk("arst_id", 32'(id4), 0);
    chk("arst_rdata", rdata4, 0);
    tick();
    reset = 1'b1;
    tick();
    rd(4'h0); chk("arst_en", rdata4, 0);
    rd(4'h8); chk("arst_pend", rdata4, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule
